// File: rtl/spi_sram_responder_if.sv
// SPI pin bundle between the SoC SPI master and the SRAM responder, plus the
// responder's status outputs.
interface spi_sram_responder_if;
  logic sck;
  logic csn;
  logic mosi;
  logic miso;
  logic miso_oe;
  logic busy;
  logic cmd_err;

  modport master (output sck, csn, mosi, input miso, miso_oe, busy, cmd_err);
  modport slave  (input sck, csn, mosi, output miso, miso_oe, busy, cmd_err);
endinterface

// File: rtl/spi_sram_responder.sv
// SPI mode-0 slave byte memory (23LC-style READ/WRITE/RDSR, sequential mode),
// running in the system clock domain by oversampling SCK (f_sck <= f_clk/8).
module spi_sram_responder #(
  parameter int unsigned AW          = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  STATUS_VAL  = 8'h40
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  spi_sram_responder_if.slave spi
);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, WDATA, RDATA, STAT, IGNORE} state_e;

  localparam logic [7:0] OP_READ  = 8'h03;
  localparam logic [7:0] OP_WRITE = 8'h02;
  localparam logic [7:0] OP_RDSR  = 8'h05;

  logic [SYNC_STAGES-1:0] sck_sync_q, csn_sync_q, mosi_sync_q;
  logic sck_rise, sck_fall, csn_s, mosi_s;

  state_e         state_q, state_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [15:0]    rx_q, rx_d;
  logic           rd_op_q, rd_op_d;
  logic           addr_hi_q, addr_hi_d;
  logic           rd_first_q, rd_first_d;
  logic [AW-1:0]  addr_q, addr_d, addr_inc;
  logic [7:0]     tx_q, tx_d;
  logic           oe_q, oe_d;
  logic           cmd_err_q, cmd_err_d;
  logic           mem_we;
  logic [7:0]     rx_byte;
  logic [15:0]    rx_word;
  logic           byte_done;

  logic [7:0]     mem_q [2**AW];

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      sck_sync_q  <= '0;
      csn_sync_q  <= '1;
      mosi_sync_q <= '0;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0],  spi.sck};
      csn_sync_q  <= {csn_sync_q[SYNC_STAGES-2:0],  spi.csn};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi.mosi};
    end
  end

  // mosi is taken from the same stage as the "current" sck so data and edge stay aligned.
  assign sck_rise = sck_sync_q[SYNC_STAGES-2] & ~sck_sync_q[SYNC_STAGES-1];
  assign sck_fall = ~sck_sync_q[SYNC_STAGES-2] & sck_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-2];
  assign csn_s    = csn_sync_q[SYNC_STAGES-1];

  assign addr_inc  = addr_q + 1'b1;
  assign rx_byte   = {rx_q[6:0], mosi_s};
  assign rx_word   = {rx_q[14:0], mosi_s};
  assign byte_done = sck_rise && (bit_cnt_q == 3'd7);

  // NOTE: every signal gets a default first so this block can never infer a latch.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    rx_d       = rx_q;
    rd_op_d    = rd_op_q;
    addr_hi_d  = addr_hi_q;
    rd_first_d = rd_first_q;
    addr_d     = addr_q;
    tx_d       = tx_q;
    oe_d       = oe_q;
    cmd_err_d  = 1'b0;
    mem_we     = 1'b0;

    if (sck_rise) begin
      bit_cnt_d = bit_cnt_q + 3'd1;
      rx_d      = rx_word;
    end

    if (csn_s) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
      tx_d      = '0;
      oe_d      = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d   = CMD;
          bit_cnt_d = '0;
          rx_d      = '0;
        end
        CMD: begin
          if (byte_done) begin
            addr_hi_d = 1'b0;
            unique case (rx_byte)
              OP_READ:  begin state_d = ADDR; rd_op_d = 1'b1; end
              OP_WRITE: begin state_d = ADDR; rd_op_d = 1'b0; end
              OP_RDSR:  state_d = STAT;
              default: begin
                state_d   = IGNORE;
                cmd_err_d = 1'b1;
              end
            endcase
          end
        end
        ADDR: begin
          if (byte_done) begin
            if (!addr_hi_q) begin
              addr_hi_d = 1'b1;
            end else begin
              addr_d     = rx_word[AW-1:0];
              rd_first_d = 1'b1;
              state_d    = rd_op_q ? RDATA : WDATA;
            end
          end
        end
        WDATA: begin
          if (byte_done) begin
            mem_we = 1'b1;
            addr_d = addr_inc;
          end
        end
        RDATA: begin
          if (sck_fall) begin
            if (rd_first_q) begin
              tx_d       = mem_q[addr_q];
              oe_d       = 1'b1;
              rd_first_d = 1'b0;
            end else if (bit_cnt_q == 3'd0) begin
              // Byte boundary: prefetch the next location so streaming has no gap.
              addr_d = addr_inc;
              tx_d   = mem_q[addr_inc];
            end else begin
              tx_d = {tx_q[6:0], 1'b0};
            end
          end
        end
        STAT: begin
          if (sck_fall) begin
            oe_d = 1'b1;
            tx_d = (bit_cnt_q == 3'd0) ? STATUS_VAL : {tx_q[6:0], 1'b0};
          end
        end
        IGNORE: oe_d = 1'b0;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      rx_q       <= '0;
      rd_op_q    <= 1'b0;
      addr_hi_q  <= 1'b0;
      rd_first_q <= 1'b0;
      addr_q     <= '0;
      tx_q       <= '0;
      oe_q       <= 1'b0;
      cmd_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_q       <= rx_d;
      rd_op_q    <= rd_op_d;
      addr_hi_q  <= addr_hi_d;
      rd_first_q <= rd_first_d;
      addr_q     <= addr_d;
      tx_q       <= tx_d;
      oe_q       <= oe_d;
      cmd_err_q  <= cmd_err_d;
    end
  end

  // NOTE: the array is deliberately not reset; contents are undefined until written.
  always_ff @(posedge wb_clk_i) begin
    if (mem_we) mem_q[addr_q] <= rx_byte;
  end

  assign spi.miso    = tx_q[7];
  assign spi.miso_oe = oe_q;
  assign spi.busy    = (state_q != IDLE);
  assign spi.cmd_err = cmd_err_q;

endmodule

// File: tb/tb_spi_sram_responder.sv
// Self-checking bench for spi_sram_responder: directed scenarios plus random
// write/readback, checked against a byte-array model of the memory.
module tb_spi_sram_responder;

  localparam int AW   = 8;
  localparam int HALF = 50;  // SCK half period; f_sck = f_clk/10

  typedef logic [7:0] bq_t[$];

  logic wb_clk_i = 1'b0;
  logic wb_rst_i = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  int   err_cycles = 0;
  int   oe_cycles  = 0;

  logic [7:0] ref_mem [2**AW];

  spi_sram_responder_if spi ();

  spi_sram_responder #(.AW(AW), .SYNC_STAGES(2), .STATUS_VAL(8'h40)) dut (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .spi      (spi.slave)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  always @(negedge wb_clk_i) begin
    if (spi.cmd_err === 1'b1) err_cycles++;
    if (spi.miso_oe === 1'b1) oe_cycles++;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cs_begin();
    spi.csn = 1'b0;
    #(HALF);
    check("busy_in_window", spi.busy, 1'b1);
  endtask

  task automatic cs_end();
    #(HALF);
    spi.csn = 1'b1;
    #(2*HALF);
    check("busy_after_window", spi.busy, 1'b0);
    check("oe_after_window", spi.miso_oe, 1'b0);
  endtask

  task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = '0;
    for (int i = 7; i > 7 - nbits; i--) begin
      spi.mosi = tx[i];
      #(HALF);
      rx[i] = spi.miso;
      spi.sck = 1'b1;
      #(HALF);
      spi.sck = 1'b0;
    end
  endtask

  task automatic do_write(input logic [15:0] addr, input bq_t data);
    logic [7:0] rx;
    cs_begin();
    xfer(8'h02, 8, rx);
    xfer(addr[15:8], 8, rx);
    xfer(addr[7:0], 8, rx);
    foreach (data[i]) begin
      xfer(data[i], 8, rx);
      ref_mem[(int'(addr) + i) % (2**AW)] = data[i];
    end
    cs_end();
  endtask

  task automatic do_read(input logic [15:0] addr, input int n, output bq_t got);
    logic [7:0] rx;
    got = {};
    cs_begin();
    xfer(8'h03, 8, rx);
    xfer(addr[15:8], 8, rx);
    xfer(addr[7:0], 8, rx);
    for (int i = 0; i < n; i++) begin
      xfer(8'h00, 8, rx);
      got.push_back(rx);
    end
    check("oe_during_read", spi.miso_oe, 1'b1);
    cs_end();
  endtask

  task automatic read_check(input string tag, input logic [15:0] addr, input int n);
    bq_t got;
    do_read(addr, n, got);
    for (int i = 0; i < n; i++)
      check(tag, got[i], ref_mem[(int'(addr) + i) % (2**AW)]);
  endtask

  initial begin
    bq_t        got;
    logic [7:0] rx;
    int         e0, o0;
    logic [15:0] ra;
    bq_t        rd;

    spi.sck  = 1'b0;
    spi.csn  = 1'b1;
    spi.mosi = 1'b0;
    #40;
    check("rst_miso", spi.miso, 1'b0);
    check("rst_oe", spi.miso_oe, 1'b0);
    check("rst_busy", spi.busy, 1'b0);
    check("rst_cmd_err", spi.cmd_err, 1'b0);
    wb_rst_i = 1'b0;
    #100;

    // Write then read back
    e0 = err_cycles;
    do_write(16'h0010, '{8'hA5, 8'h5A, 8'h3C});
    check("no_err_on_write", err_cycles - e0, 0);
    do_read(16'h0010, 3, got);
    check("wr_rd_b0", got[0], 8'hA5);
    check("wr_rd_b1", got[1], 8'h5A);
    check("wr_rd_b2", got[2], 8'h3C);

    // Address wrap
    do_write(16'h00FE, '{8'h11, 8'h22, 8'h33});
    do_read(16'h00FE, 3, got);
    check("wrap_b0", got[0], 8'h11);
    check("wrap_b1", got[1], 8'h22);
    check("wrap_b2", got[2], 8'h33);
    do_read(16'h0000, 1, got);
    check("wrap_addr0", got[0], 8'h33);

    // High address bits ignored
    do_write(16'hAB05, '{8'h77});
    do_read(16'h0005, 1, got);
    check("high_addr_ignored", got[0], 8'h77);

    // RDSR
    cs_begin();
    xfer(8'h05, 8, rx);
    xfer(8'h00, 8, rx);
    check("rdsr_0", rx, 8'h40);
    xfer(8'h00, 8, rx);
    check("rdsr_1", rx, 8'h40);
    cs_end();

    // Unsupported opcode
    e0 = err_cycles;
    o0 = oe_cycles;
    cs_begin();
    xfer(8'h9F, 8, rx);
    xfer(8'h00, 8, rx);
    xfer(8'h00, 8, rx);
    cs_end();
    check("bad_op_err_pulse", err_cycles - e0, 1);
    check("bad_op_oe_low", oe_cycles - o0, 0);

    // Abort mid-byte leaves the next location untouched
    do_write(16'h0021, '{8'h99});
    cs_begin();
    xfer(8'h02, 8, rx);
    xfer(8'h00, 8, rx);
    xfer(8'h20, 8, rx);
    xfer(8'hC3, 8, rx);
    xfer(8'hF0, 4, rx);
    cs_end();
    ref_mem[8'h20] = 8'hC3;
    do_read(16'h0020, 2, got);
    check("abort_b0", got[0], 8'hC3);
    check("abort_b1", got[1], 8'h99);

    // Reset during the second data byte of a read
    cs_begin();
    xfer(8'h03, 8, rx);
    xfer(8'h00, 8, rx);
    xfer(8'h10, 8, rx);
    xfer(8'h00, 8, rx);
    check("pre_rst_byte", rx, 8'hA5);
    xfer(8'h00, 3, rx);
    wb_rst_i = 1'b1;
    #10;
    check("midrst_miso", spi.miso, 1'b0);
    check("midrst_oe", spi.miso_oe, 1'b0);
    check("midrst_busy", spi.busy, 1'b0);
    spi.csn = 1'b1;
    #20;
    wb_rst_i = 1'b0;
    #100;
    read_check("post_rst_read", 16'h0010, 3);

    // Random write/readback against the model
    for (int t = 0; t < 6; t++) begin
      int n;
      rd = {};
      ra = 16'($urandom);
      n  = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) rd.push_back(8'($urandom));
      do_write(ra, rd);
      read_check("rand_readback", {8'($urandom), ra[7:0]}, n);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL timeout: observed running expected finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_sram_responder.md
Name: spi_sram_responder

Overview:
- Synthesizable SPI-slave byte memory. It is the responder end of the SoC's SPI master (SPI0 pins MSO/MSI/SSn/SCLK).
- Lets the user project carry on-chip scratch RAM reachable through the SPI peripheral, in place of an external 23LC512-class device.
- Implements the 23LC-style READ/WRITE/RDSR command subset in sequential mode.
- Runs entirely in the system clock domain by oversampling SCK.

Parameters:
- AW, 8, memory address width; depth = 2**AW bytes. Only the low AW bits of the 16-bit SPI address are used.
- SYNC_STAGES, 2, synchronizer depth on sck, csn and mosi (minimum 2).
- STATUS_VAL, 8'h40, constant byte returned by RDSR (sequential mode).

Ports:
- wb_clk_i  in  1  system clock. Reset is asynchronous and active-high.
- wb_rst_i  in  1  asynchronous active-high reset.
- sck  in  1  SPI clock from master; mode 0 (CPOL=0, CPHA=0).
- csn  in  1  chip select, active low.
- mosi  in  1  master-out data.
- miso  out  1  slave-out data.
- miso_oe  out  1  high while the block drives miso.
- busy  out  1  high while a transaction is active (synchronized csn low).
- cmd_err  out  1  one-cycle pulse when an unsupported opcode is received.

Behaviour:
- Reset values: miso=0, miso_oe=0, busy=0, cmd_err=0, FSM=IDLE, bit counter=0, address=0. Memory array is not reset; contents are undefined until written.
- Synchronization: sck, csn and mosi each pass through SYNC_STAGES flops. Edges are detected from the last two sync stages.
  - rise = rising SCK edge; fall = falling SCK edge.
  - Requirement: f_sck <= f_wb_clk_i/8.
- Sampling: mosi is sampled on rise, MSB first. miso changes only on fall, or on the cycle the FSM enters a read phase.
- Bit counter: 3 bits, increments on each rise. A byte completes when it wraps 7 -> 0.
- CSn low (synchronized) enters CMD; bit counter is cleared.
- CSn high (synchronized) at any time, from any state, forces IDLE on the next cycle:
  - miso_oe=0, miso=0, busy=0;
  - a partially received write byte is discarded;
  - the address register is kept but is irrelevant to the next transaction.
- FSM states: IDLE, CMD, ADDR, WDATA, RDATA, STAT, IGNORE.
  - CMD: after 8 bits, decode the opcode.
    - 0x03 -> ADDR (read).
    - 0x02 -> ADDR (write).
    - 0x05 -> STAT.
    - Any other opcode -> IGNORE, with cmd_err pulsed for exactly one cycle.
  - ADDR: 16 bits are shifted in. The low AW bits load the address register on the 16th rise. Then go to RDATA or WDATA per the latched opcode.
  - RDATA:
    - On the first fall after the last address bit: load the shift register with mem[addr], drive its MSB, set miso_oe=1.
    - Each subsequent fall shifts out the next bit.
    - On the fall after the 8th data rise: increment addr and load mem[addr+1], so streaming is seamless.
  - WDATA: on the 8th rise of each data byte, write mem[addr] <= byte in that same wb_clk_i cycle, then increment addr.
  - Address arithmetic: AW-bit, wraps 2**AW-1 -> 0 for both reads and writes.
  - STAT: on the first fall, drive STATUS_VAL MSB-first with miso_oe=1. It repeats every 8 bits while CSn stays low.
  - IGNORE: miso_oe=0; all sck activity is ignored until CSn goes high.
- Read-after-write in the same transaction is impossible by construction: a transaction is either read or write.
- Read hazard: a read of an address written in the immediately preceding transaction must return the new value. Memory is written synchronously, so this holds by construction.
- Reset asserted mid-transaction: immediate return to reset values. A byte not yet committed is not written.

Test Plan:
- Write then read back:
  - CSn low, send 02 00 10 A5 5A 3C, CSn high.
  - CSn low, send 03 00 10 + 24 dummy clocks.
  - miso bytes A5 5A 3C; busy high only during each CSn-low window.
- Address wrap (AW=8):
  - Write 02 00 FE 11 22 33, then read 03 00 FE for 3 bytes -> 11 22 33.
  - Read 03 00 00 for 1 byte -> 33.
- High address bits ignored: write 02 AB 05 77, read 03 00 05 -> 77.
- RDSR and bad opcode:
  - Send 05 + 16 clocks -> 40 40.
  - Send 9F -> cmd_err single-cycle pulse; miso_oe stays 0 for the rest of the CSn window.
- Abort mid-byte:
  - Write 02 00 20 C3, then 4 bits of 0xF0, then CSn high.
  - Read 03 00 20 for 2 bytes -> C3 then the prior content of 0x21 (pre-written 0x99).
  - 0x21 was not modified.
- Reset mid-read: assert wb_rst_i during the second data byte of a read -> miso=0, miso_oe=0, busy=0 within one cycle. A fresh read afterwards returns correct data.
